// File: rtl/wrapper_1500_param.sv
// IEEE 1500-style core wrapper: WIR, 1-bit bypass and a boundary register that
// sits between chip pins (pi/po) and an unwrapped core (core_in/core_out).
module wrapper_1500_param #(
  parameter int              N_IN     = 4,
  parameter int              N_OUT    = 4,
  parameter logic [N_IN-1:0] SAFE_IN  = '0,
  parameter logic [N_OUT-1:0] SAFE_OUT = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wsi,
  output logic             wso,
  input  logic             select_wir,
  input  logic             shift_wr,
  input  logic             capture_wr,
  input  logic             update_wr,
  input  logic [N_IN-1:0]  pi,
  output logic [N_OUT-1:0] po,
  output logic [N_IN-1:0]  core_in,
  input  logic [N_OUT-1:0] core_out,
  output logic [2:0]       instr
);

  localparam int L = N_IN + N_OUT;

  localparam logic [2:0] I_EXTEST = 3'b001;
  localparam logic [2:0] I_INTEST = 3'b010;
  localparam logic [2:0] I_SAMPLE = 3'b011;

  logic [2:0]   wir_sh_reg;
  logic [2:0]   instr_reg;
  logic         wby_reg;
  logic [L-1:0] wbr_sh_reg;
  logic [L-1:0] wbr_upd_reg;

  logic         is_extest;
  logic         is_intest;
  logic         is_sample;
  logic         sel_wbr;
  logic         cap_in_cells;
  logic         cap_out_cells;
  logic [L-1:0] cap_mask;
  logic [L-1:0] cap_data;
  logic [L-1:0] wbr_cap_next;

  // FUNCTIONAL and every unlisted code fall through to the bypass path.
  always_comb begin
    is_extest = (instr_reg == I_EXTEST);
    is_intest = (instr_reg == I_INTEST);
    is_sample = (instr_reg == I_SAMPLE);
    sel_wbr   = is_extest | is_intest | is_sample;
  end

  // Capture only overwrites the cells the current mode observes; the rest hold.
  assign cap_in_cells  = is_extest | is_sample;
  assign cap_out_cells = is_intest | is_sample;
  assign cap_mask      = {{N_IN{cap_in_cells}}, {N_OUT{cap_out_cells}}};
  assign cap_data      = {pi, core_out};
  assign wbr_cap_next  = (wbr_sh_reg & ~cap_mask) | (cap_data & cap_mask);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wir_sh_reg  <= 3'b000;
      instr_reg   <= 3'b000;
      wby_reg     <= 1'b0;
      wbr_sh_reg  <= '0;
      wbr_upd_reg <= '0;
    end else if (select_wir) begin
      if (capture_wr)
        wir_sh_reg <= instr_reg;
      else if (shift_wr)
        wir_sh_reg <= {wsi, wir_sh_reg[2:1]};
      else if (update_wr)
        instr_reg <= wir_sh_reg;
    end else if (sel_wbr) begin
      // Update stage is only written when neither capture nor shift is active.
      if (capture_wr)
        wbr_sh_reg <= wbr_cap_next;
      else if (shift_wr)
        wbr_sh_reg <= {wsi, wbr_sh_reg[L-1:1]};
      else if (update_wr)
        wbr_upd_reg <= wbr_sh_reg;
    end else begin
      if (capture_wr)
        wby_reg <= 1'b0;
      else if (shift_wr)
        wby_reg <= wsi;
    end
  end

  always_comb begin
    if (select_wir)
      wso = wir_sh_reg[0];
    else if (sel_wbr)
      wso = wbr_sh_reg[0];
    else
      wso = wby_reg;
  end

  always_comb begin
    core_in = pi;
    po      = core_out;
    if (is_extest) begin
      core_in = SAFE_IN;
      po      = wbr_upd_reg[N_OUT-1:0];
    end else if (is_intest) begin
      core_in = wbr_upd_reg[L-1:N_OUT];
      po      = SAFE_OUT;
    end
  end

  assign instr = instr_reg;

endmodule

// File: tb/tb_wrapper_1500_param.sv
// Directed bench for wrapper_1500_param: reset, WIR load, EXTEST, INTEST,
// bypass on an illegal code and capture/shift priority.
module tb_wrapper_1500_param;

  logic       clk;
  logic       reset_n;
  logic       wsi;
  logic       wso;
  logic       select_wir;
  logic       shift_wr;
  logic       capture_wr;
  logic       update_wr;
  logic [3:0] pi;
  logic [3:0] po;
  logic [3:0] core_in;
  logic [3:0] core_out;
  logic [2:0] instr;

  int errors = 0;
  int checks = 0;

  wrapper_1500_param #(
    .N_IN(4), .N_OUT(4), .SAFE_IN(4'h0), .SAFE_OUT(4'h0)
  ) dut (
    .clk(clk), .reset_n(reset_n), .wsi(wsi), .wso(wso),
    .select_wir(select_wir), .shift_wr(shift_wr), .capture_wr(capture_wr),
    .update_wr(update_wr), .pi(pi), .po(po), .core_in(core_in),
    .core_out(core_out), .instr(instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic shift_bit(input logic b);
    shift_wr = 1'b1;
    wsi      = b;
    step();
    shift_wr = 1'b0;
    wsi      = 1'b0;
  endtask

  task automatic pulse_update();
    update_wr = 1'b1;
    step();
    update_wr = 1'b0;
  endtask

  task automatic pulse_capture();
    capture_wr = 1'b1;
    step();
    capture_wr = 1'b0;
  endtask

  task automatic wir_load(input logic [2:0] code);
    select_wir = 1'b1;
    for (int i = 0; i < 3; i++) shift_bit(code[i]);
    pulse_update();
    select_wir = 1'b0;
  endtask

  task automatic wbr_shift_in(input logic [7:0] v);
    for (int i = 0; i < 8; i++) shift_bit(v[i]);
  endtask

  task automatic wbr_shift_out(input string tag, input logic [7:0] exp);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("%s[%0d]", tag, i), {31'b0, wso}, {31'b0, exp[i]});
      shift_bit(1'b0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n    = 1'b0;
    wsi        = 1'b0;
    select_wir = 1'b0;
    shift_wr   = 1'b0;
    capture_wr = 1'b0;
    update_wr  = 1'b0;
    pi         = 4'hA;
    core_out   = 4'h5;
    step();
    step();
    check("rst_instr", {29'b0, instr}, 32'h0);
    check("rst_core_in", {28'b0, core_in}, 32'hA);
    check("rst_po", {28'b0, po}, 32'h5);
    check("rst_wso", {31'b0, wso}, 32'h0);
    reset_n = 1'b1;
    step();

    // Reset in the middle of a WIR shift
    select_wir = 1'b1;
    shift_bit(1'b1);
    shift_bit(1'b1);
    reset_n = 1'b0;
    #1;
    check("midrst_instr", {29'b0, instr}, 32'h0);
    check("midrst_wso", {31'b0, wso}, 32'h0);
    step();
    reset_n = 1'b1;
    step();

    // WIR load of EXTEST, bits 1,0,0 from a cleared register
    shift_bit(1'b1);
    check("wir_sh1_wso", {31'b0, wso}, 32'h0);
    shift_bit(1'b0);
    shift_bit(1'b0);
    check("wir_sh3_wso", {31'b0, wso}, 32'h1);
    check("wir_pre_upd_instr", {29'b0, instr}, 32'h0);
    pulse_update();
    check("wir_upd_instr", {29'b0, instr}, 32'h1);
    pulse_capture();
    check("wir_cap_wso0", {31'b0, wso}, 32'h1);
    shift_bit(1'b0);
    check("wir_cap_wso1", {31'b0, wso}, 32'h0);
    shift_bit(1'b0);
    check("wir_cap_wso2", {31'b0, wso}, 32'h0);
    select_wir = 1'b0;

    // EXTEST: po must not ripple while shifting 8'h0C
    check("ext_core_in_safe", {28'b0, core_in}, 32'h0);
    for (int i = 0; i < 8; i++) begin
      logic [7:0] v;
      v = 8'h0C;
      shift_bit(v[i]);
      check($sformatf("ext_po_during_shift[%0d]", i), {28'b0, po}, 32'h0);
    end
    pulse_update();
    check("ext_po_upd", {28'b0, po}, 32'hC);
    check("ext_core_in_upd", {28'b0, core_in}, 32'h0);
    pi = 4'h9;
    pulse_capture();
    wbr_shift_out("ext_wso", 8'h9C);
    check("ext_po_hold", {28'b0, po}, 32'hC);

    // INTEST: drive in_cells=3 into the core, observe core_out=6
    wir_load(3'b010);
    check("int_instr", {29'b0, instr}, 32'h2);
    wbr_shift_in(8'h30);
    pulse_update();
    core_out = 4'h6;
    #1;
    check("int_core_in", {28'b0, core_in}, 32'h3);
    check("int_po_safe", {28'b0, po}, 32'h0);
    pulse_capture();
    wbr_shift_out("int_wso", 8'h36);

    // Illegal code 101 behaves as BYPASS
    wir_load(3'b101);
    check("byp_instr", {29'b0, instr}, 32'h5);
    pi       = 4'hA;
    core_out = 4'h5;
    #1;
    check("byp_core_in", {28'b0, core_in}, 32'hA);
    check("byp_po", {28'b0, po}, 32'h5);
    shift_bit(1'b1);
    check("byp_wso_1", {31'b0, wso}, 32'h1);
    shift_bit(1'b0);
    check("byp_wso_0", {31'b0, wso}, 32'h0);
    shift_bit(1'b1);
    pulse_capture();
    check("byp_cap_clears", {31'b0, wso}, 32'h0);

    // Priority: capture beats shift in SAMPLE, then a lone update
    wir_load(3'b011);
    pi       = 4'hF;
    core_out = 4'h0;
    #1;
    check("smp_core_in", {28'b0, core_in}, 32'hF);
    check("smp_po", {28'b0, po}, 32'h0);
    capture_wr = 1'b1;
    shift_wr   = 1'b1;
    wsi        = 1'b1;
    step();
    capture_wr = 1'b0;
    shift_wr   = 1'b0;
    wsi        = 1'b0;
    pulse_update();
    wir_load(3'b001);
    check("pri_upd_out_cells", {28'b0, po}, 32'h0);
    wir_load(3'b010);
    check("pri_upd_in_cells", {28'b0, core_in}, 32'hF);
    wbr_shift_out("pri_sh", 8'hF0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
